// File: rtl/bram_rx_mc_ctrl_pkg.sv
// Shared types and constants for the multi-channel BRAM receive controller.
package bram_rx_mc_ctrl_pkg;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_RECV   = 2'd1,
    CH_LOCKED = 2'd2
  } ch_state_t;

  localparam int unsigned DEF_N_CH   = 2;
  localparam int unsigned DEF_REG_AW = 11;
  localparam int unsigned NSK_LIMIT  = 512;
  localparam int unsigned VSK_LIMIT  = 1024;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bram_rx_mc_ctrl_rr_arbiter.sv
// N-request round-robin arbiter: one-hot grant, search starts at the pointer,
// pointer moves to granted+1 whenever a grant is issued.
module bram_rx_mc_ctrl_rr_arbiter
  import bram_rx_mc_ctrl_pkg::*;
#(
  parameter int unsigned N = DEF_N_CH,
  localparam int unsigned IW = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW-1:0] r_ptr;

  always_comb begin
    int unsigned k;
    k       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      k = int'(r_ptr) + i;
      if (k >= N) k = k - N;
      if (!o_valid && i_req[k]) begin
        o_valid    = 1'b1;
        o_grant[k] = 1'b1;
        o_idx      = IW'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (o_valid) begin
      r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + IW'(1);
    end
  end

endmodule

// File: rtl/bram_rx_mc_ctrl.sv
// Multi-channel receive controller: arbitrates N_CH word streams into private
// regions of one shared BRAM with per-packet truncation and host-released locks.
module bram_rx_mc_ctrl
  import bram_rx_mc_ctrl_pkg::*;
#(
  parameter int unsigned N_CH   = DEF_N_CH,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = DEF_REG_AW,
  parameter int unsigned ADDR_W = 14,
  localparam int unsigned CW = clog2_min1(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   s_data,
  input  logic [N_CH-1:0]          s_valid,
  input  logic [N_CH-1:0]          s_last,
  output logic [N_CH-1:0]          s_ready,
  input  logic [REG_AW:0]          cfg_limit,
  input  logic [N_CH-1:0]          ch_release,
  output logic                     bram_we,
  output logic [ADDR_W-1:0]        bram_addr,
  output logic [DATA_W-1:0]        bram_wdata,
  output logic                     pkt_done,
  output logic [CW-1:0]            pkt_ch,
  output logic [REG_AW:0]          pkt_len,
  output logic                     pkt_trunc,
  output logic [N_CH-1:0]          ch_locked
);

  localparam logic [REG_AW:0] FULL = {1'b1, {REG_AW{1'b0}}};

  logic [REG_AW:0]   w_eff_cfg;
  logic [N_CH-1:0]   w_eligible;
  logic [N_CH-1:0]   w_acc;
  logic [N_CH-1:0]   w_store;
  logic [N_CH-1:0]   w_trunc;
  logic [REG_AW:0]   w_cnt [N_CH];
  logic [CW-1:0]     w_gidx;
  logic              w_gvalid;

  logic              w_sel_store;
  logic              w_sel_last;
  logic              w_sel_trunc;
  logic [REG_AW:0]   w_sel_cnt;
  logic [DATA_W-1:0] w_sel_data;

  logic              r_p1_done;
  logic [CW-1:0]     r_p1_ch;
  logic [REG_AW:0]   r_p1_len;
  logic              r_p1_trunc;

  assign w_eff_cfg = (cfg_limit == '0 || cfg_limit > FULL) ? FULL : cfg_limit;

  bram_rx_mc_ctrl_rr_arbiter #(.N(N_CH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (w_eligible),
    .o_grant (s_ready),
    .o_idx   (w_gidx),
    .o_valid (w_gvalid)
  );

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    ch_state_t       r_state;
    ch_state_t       w_next;
    logic [REG_AW:0] r_cnt;
    logic [REG_AW:0] r_lim;
    logic [REG_AW:0] w_lim;
    logic            r_trunc;
    logic            r_locked;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= CH_IDLE;
      else     r_state <= w_next;
    end

    always_comb begin
      w_next = r_state;
      case (r_state)
        CH_IDLE:   if (w_acc[c]) w_next = s_last[c] ? CH_LOCKED : CH_RECV;
        CH_RECV:   if (w_acc[c] && s_last[c]) w_next = CH_LOCKED;
        CH_LOCKED: if (ch_release[c]) w_next = CH_IDLE;
        default:   w_next = CH_IDLE;
      endcase
    end

    // The limit is taken live from cfg_limit on a packet's first word, then held.
    always_comb begin
      w_eligible[c] = s_valid[c] && (r_state != CH_LOCKED);
      w_lim         = (r_state == CH_IDLE) ? w_eff_cfg : r_lim;
    end

    assign w_acc[c]   = s_valid[c] & s_ready[c];
    assign w_store[c] = w_acc[c] && (r_cnt < w_lim);
    assign w_trunc[c] = r_trunc;
    assign w_cnt[c]   = r_cnt;
    assign ch_locked[c] = r_locked;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt    <= '0;
        r_lim    <= '0;
        r_trunc  <= 1'b0;
        r_locked <= 1'b0;
      end else begin
        r_locked <= (w_next == CH_LOCKED);
        if (r_state == CH_LOCKED && ch_release[c]) begin
          r_cnt   <= '0;
          r_trunc <= 1'b0;
        end else if (w_acc[c]) begin
          if (r_state == CH_IDLE) r_lim <= w_eff_cfg;
          if (w_store[c]) r_cnt   <= r_cnt + 1'b1;
          else            r_trunc <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_sel_store = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_trunc = 1'b0;
    w_sel_cnt   = '0;
    w_sel_data  = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (s_ready[c]) begin
        w_sel_store = w_store[c];
        w_sel_last  = s_last[c];
        w_sel_trunc = w_trunc[c];
        w_sel_cnt   = w_cnt[c];
        w_sel_data  = s_data[c*DATA_W +: DATA_W];
      end
    end
  end

  // Completion info is captured at acceptance so a fast release cannot clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      r_p1_done  <= 1'b0;
      r_p1_ch    <= '0;
      r_p1_len   <= '0;
      r_p1_trunc <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_ch     <= '0;
      pkt_len    <= '0;
      pkt_trunc  <= 1'b0;
    end else begin
      bram_we <= w_gvalid & w_sel_store;
      if (w_gvalid & w_sel_store) begin
        bram_addr  <= (ADDR_W'(w_gidx) << REG_AW) | ADDR_W'(w_sel_cnt[REG_AW-1:0]);
        bram_wdata <= w_sel_data;
      end
      r_p1_done <= w_gvalid & w_sel_last;
      if (w_gvalid & w_sel_last) begin
        r_p1_ch    <= w_gidx;
        r_p1_len   <= w_sel_cnt + {{REG_AW{1'b0}}, w_sel_store};
        r_p1_trunc <= w_sel_trunc | ~w_sel_store;
      end
      pkt_done <= r_p1_done;
      if (r_p1_done) begin
        pkt_ch    <= r_p1_ch;
        pkt_len   <= r_p1_len;
        pkt_trunc <= r_p1_trunc;
      end
    end
  end

endmodule

// File: tb/tb_bram_rx_mc_ctrl.sv
// Randomised bench for bram_rx_mc_ctrl with a transaction-level reference model.
module tb_bram_rx_mc_ctrl;

  localparam int N_CH   = 2;
  localparam int DATA_W = 32;
  localparam int REG_AW = 11;
  localparam int ADDR_W = 14;
  localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int LW     = REG_AW + 1;
  localparam int FULL   = 1 << REG_AW;
  localparam int TXD    = 4096;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_CH*DATA_W-1:0] s_data = '0;
  logic [N_CH-1:0]        s_valid = '0;
  logic [N_CH-1:0]        s_last = '0;
  logic [N_CH-1:0]        s_ready;
  logic [REG_AW:0]        cfg_limit = '0;
  logic [N_CH-1:0]        ch_release = '0;
  logic                   bram_we;
  logic [ADDR_W-1:0]      bram_addr;
  logic [DATA_W-1:0]      bram_wdata;
  logic                   pkt_done;
  logic [CW-1:0]          pkt_ch;
  logic [REG_AW:0]        pkt_len;
  logic                   pkt_trunc;
  logic [N_CH-1:0]        ch_locked;

  always #5 clk = ~clk;

  bram_rx_mc_ctrl #(.N_CH(N_CH), .DATA_W(DATA_W), .REG_AW(REG_AW), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .cfg_limit(cfg_limit), .ch_release(ch_release),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .pkt_done(pkt_done), .pkt_ch(pkt_ch), .pkt_len(pkt_len), .pkt_trunc(pkt_trunc),
    .ch_locked(ch_locked)
  );

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  // Per-channel source FIFOs of words still to be offered.
  logic [DATA_W-1:0] tx_data [N_CH][TXD];
  bit                tx_last [N_CH][TXD];
  int                tx_head [N_CH];
  int                tx_tail [N_CH];

  // Reference model: per-channel packet bookkeeping and expected output events.
  bit m_locked [N_CH];
  bit m_busy   [N_CH];
  bit m_trunc  [N_CH];
  int m_cnt    [N_CH];
  int m_lim    [N_CH];
  int m_ptr;

  typedef struct { int cyc; int addr; logic [DATA_W-1:0] data; } wr_t;
  typedef struct { int cyc; int ch; int len; bit trunc; } dn_t;
  wr_t wr_q[$];
  dn_t dn_q[$];
  int  last_ch, last_len;
  bit  last_trunc;

  function automatic int eff_limit(input int v);
    return (v == 0 || v > FULL) ? FULL : v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_locked[c] = 0; m_busy[c] = 0; m_trunc[c] = 0; m_cnt[c] = 0; m_lim[c] = 0;
      tx_head[c] = 0; tx_tail[c] = 0;
    end
    m_ptr = 0;
    wr_q.delete();
    dn_q.delete();
    last_ch = 0; last_len = 0; last_trunc = 0;
  endtask

  task automatic push_pkt(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      tx_data[c][tx_tail[c] % TXD] = $urandom;
      tx_last[c][tx_tail[c] % TXD] = (i == n - 1);
      tx_tail[c]++;
    end
  endtask

  function automatic bit all_empty();
    bit e;
    e = (wr_q.size() == 0) && (dn_q.size() == 0);
    for (int c = 0; c < N_CH; c++) if (tx_head[c] != tx_tail[c]) e = 0;
    return e;
  endfunction

  // One clock: drive, compare every output against the model, advance the model.
  task automatic cycle(input logic [N_CH-1:0] gate, input logic [N_CH-1:0] rel);
    logic [N_CH-1:0] v, exp_ready, lk, rel_eff;
    int g, k;
    bit exp_done;
    for (int c = 0; c < N_CH; c++) begin
      v[c] = gate[c] && (tx_head[c] != tx_tail[c]);
      s_valid[c] = v[c];
      s_data[c*DATA_W +: DATA_W] = tx_data[c][tx_head[c] % TXD];
      s_last[c] = v[c] && tx_last[c][tx_head[c] % TXD];
    end
    ch_release = rel;
    @(negedge clk);

    g = -1;
    for (int i = 0; i < N_CH; i++) begin
      k = (m_ptr + i) % N_CH;
      if (g < 0 && v[k] && !m_locked[k]) g = k;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    checks++;
    if (s_ready !== exp_ready) begin
      failures++;
      $display("FAIL s_ready cyc=%0d got=%b exp=%b", cyc_n, s_ready, exp_ready);
    end

    for (int c = 0; c < N_CH; c++) lk[c] = m_locked[c];
    checks++;
    if (ch_locked !== lk) begin
      failures++;
      $display("FAIL ch_locked cyc=%0d got=%b exp=%b", cyc_n, ch_locked, lk);
    end

    checks++;
    if (wr_q.size() > 0 && wr_q[0].cyc == cyc_n) begin
      if (bram_we !== 1'b1 || bram_addr !== ADDR_W'(wr_q[0].addr) || bram_wdata !== wr_q[0].data) begin
        failures++;
        $display("FAIL bram_write cyc=%0d got we=%b addr=%0d data=%h exp we=1 addr=%0d data=%h",
                 cyc_n, bram_we, bram_addr, bram_wdata, wr_q[0].addr, wr_q[0].data);
      end
      void'(wr_q.pop_front());
    end else if (bram_we !== 1'b0) begin
      failures++;
      $display("FAIL bram_we_idle cyc=%0d got=%b exp=0 addr=%0d", cyc_n, bram_we, bram_addr);
    end

    exp_done = 0;
    if (dn_q.size() > 0 && dn_q[0].cyc == cyc_n) begin
      exp_done = 1;
      last_ch = dn_q[0].ch; last_len = dn_q[0].len; last_trunc = dn_q[0].trunc;
      void'(dn_q.pop_front());
    end
    checks++;
    if (pkt_done !== exp_done || pkt_ch !== CW'(last_ch) || pkt_len !== LW'(last_len) ||
        pkt_trunc !== last_trunc) begin
      failures++;
      $display("FAIL pkt_info cyc=%0d got done=%b ch=%0d len=%0d trunc=%b exp done=%b ch=%0d len=%0d trunc=%b",
               cyc_n, pkt_done, pkt_ch, pkt_len, pkt_trunc, exp_done, last_ch, last_len, last_trunc);
    end

    for (int c = 0; c < N_CH; c++) rel_eff[c] = rel[c] && m_locked[c];
    if (g >= 0) begin
      if (!m_busy[g]) begin
        m_busy[g] = 1;
        m_lim[g]  = eff_limit(int'(cfg_limit));
      end
      if (m_cnt[g] < m_lim[g]) begin
        wr_q.push_back('{cyc: cyc_n + 1, addr: g * FULL + m_cnt[g],
                         data: tx_data[g][tx_head[g] % TXD]});
        m_cnt[g]++;
      end else begin
        m_trunc[g] = 1;
      end
      if (tx_last[g][tx_head[g] % TXD]) begin
        m_locked[g] = 1;
        m_busy[g]   = 0;
        dn_q.push_back('{cyc: cyc_n + 2, ch: g, len: m_cnt[g], trunc: m_trunc[g]});
      end
      tx_head[g]++;
      m_ptr = (g + 1) % N_CH;
    end
    for (int c = 0; c < N_CH; c++) begin
      if (rel_eff[c]) begin
        m_locked[c] = 0; m_cnt[c] = 0; m_trunc[c] = 0;
      end
    end

    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic drain(input int budget, input logic [N_CH-1:0] rel);
    int n;
    n = 0;
    while (!all_empty() && n < budget) begin
      cycle('1, rel);
      n++;
    end
    checks++;
    if (!all_empty()) begin
      failures++;
      $display("FAIL drain_timeout cyc=%0d budget=%0d exp=empty", cyc_n, budget);
    end
  endtask

  task automatic check_pkt(input string name, input int ch, input int len, input bit tr);
    checks++;
    if (pkt_ch !== CW'(ch) || pkt_len !== LW'(len) || pkt_trunc !== tr) begin
      failures++;
      $display("FAIL %s got ch=%0d len=%0d trunc=%b exp ch=%0d len=%0d trunc=%b",
               name, pkt_ch, pkt_len, pkt_trunc, ch, len, tr);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (s_ready !== '0 || bram_we !== 1'b0 || bram_addr !== '0 || bram_wdata !== '0 ||
        pkt_done !== 1'b0 || pkt_ch !== '0 || pkt_len !== '0 || pkt_trunc !== 1'b0 ||
        ch_locked !== '0) begin
      failures++;
      $display("FAIL %s got rdy=%b we=%b addr=%0d data=%h done=%b ch=%0d len=%0d tr=%b lk=%b exp all 0",
               name, s_ready, bram_we, bram_addr, bram_wdata, pkt_done, pkt_ch, pkt_len,
               pkt_trunc, ch_locked);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    check_zero("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_held");
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    cfg_limit = '0;
    push_pkt(0, 4);
    drain(20, '0);
    check_pkt("single_pkt", 0, 4, 0);
    checks++;
    if (ch_locked !== 2'b01) begin
      failures++;
      $display("FAIL single_locked got=%b exp=01", ch_locked);
    end
    cycle('0, 2'b01);
    cycle('0, '0);
  endtask

  task automatic test_back_to_back();
    push_pkt(0, 3);
    push_pkt(1, 3);
    drain(20, '0);
    cycle('0, 2'b11);
    cycle('0, '0);
  endtask

  task automatic test_trunc();
    cfg_limit = LW'(2);
    push_pkt(1, 5);
    drain(20, '0);
    check_pkt("trunc_pkt", 1, 2, 1);
    cycle('0, 2'b10);
  endtask

  task automatic test_locked_hold();
    cfg_limit = '0;
    push_pkt(0, 1);
    drain(10, '0);
    push_pkt(0, 3);
    repeat (10) cycle(2'b01, '0);
    cycle(2'b01, 2'b01);
    drain(20, '0);
    check_pkt("relock_pkt", 0, 3, 0);
    cycle('0, 2'b01);
  endtask

  task automatic test_reset_mid();
    push_pkt(0, 5);
    cycle('1, '0);
    cycle('1, '0);
    s_valid = '0;
    s_last  = '0;
    #1;
    rst = 1'b1;
    #1;
    check_zero("reset_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    push_pkt(0, 3);
    drain(20, '0);
    check_pkt("post_reset_pkt", 0, 3, 0);
    cycle('0, 2'b01);
  endtask

  task automatic test_full_limit();
    cfg_limit = LW'(FULL);
    push_pkt(0, FULL + 1);
    drain(FULL + 20, '0);
    check_pkt("full_pkt", 0, FULL, 1);
    cycle('0, 2'b01);
  endtask

  task automatic test_random();
    logic [N_CH-1:0] gate, rel;
    int lims[6];
    lims = '{0, 1, 2, 3, 5, 4095};
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (tx_head[c] == tx_tail[c] && $urandom_range(0, 3) == 0)
          push_pkt(c, $urandom_range(1, 6));
        gate[c] = ($urandom_range(0, 3) != 0);
        rel[c]  = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 15) == 0) cfg_limit = LW'(lims[$urandom_range(0, 5)]);
      cycle(gate, rel);
    end
    drain(200, '1);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_trunc();
    test_locked_hold();
    test_reset_mid();
    test_full_limit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_rx_mc_ctrl.md
Name: bram_rx_mc_ctrl

Overview:
- Multi-channel receive controller: accepts word streams from N_CH sources and writes each packet into that channel's private region of one shared BRAM.
- Applies a runtime per-packet length limit with truncation.
- Locks a region after packet completion until the host releases it.
- Sits between the link deserialisers (NSK/VSK channels) and the AXI-side BRAM reader; generalises the fixed two-channel NSK/VSK buffering to N channels of parametrised width and depth.

Parameters:
N_CH, 2, number of input channels (1..8)
DATA_W, 32, stream/BRAM word width
REG_AW, 11, log2 words per channel region (2048 words)
ADDR_W, 14, BRAM word-address width; must be >= REG_AW + clog2(N_CH)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
s_data  in  N_CH*DATA_W  per-channel input word, channel c at bits [c*DATA_W +: DATA_W]
s_valid  in  N_CH  per-channel word valid
s_last  in  N_CH  per-channel last word of packet
s_ready  out  N_CH  per-channel accept
cfg_limit  in  REG_AW+1  max stored words per packet; 0 or >2^REG_AW means 2^REG_AW
ch_release  in  N_CH  host pulse: region read out, unlock channel
bram_we  out  1  BRAM write enable
bram_addr  out  ADDR_W  BRAM word address
bram_wdata  out  DATA_W  BRAM write data
pkt_done  out  1  one-cycle pulse: packet committed
pkt_ch  out  clog2(N_CH) (min 1)  channel of pkt_done
pkt_len  out  REG_AW+1  stored word count of the packet
pkt_trunc  out  1  packet exceeded the limit and was truncated
ch_locked  out  N_CH  region holds an unreleased packet

Behaviour:
- Reset: all outputs 0; per-channel counters 0; all channels IDLE; round-robin pointer 0.
- Per-channel FSM:
  - IDLE: no packet in progress; first accepted word -> RECV.
  - RECV: packet in progress; accepted word with s_last -> LOCKED.
  - LOCKED: region holds a packet; ch_release[c] -> IDLE.
  - Single-word packet: IDLE -> LOCKED directly.
- Eligibility: channel eligible when state != LOCKED and s_valid[c]=1.
- Arbitration: round-robin; exactly one eligible channel granted per cycle. s_ready[c] is combinational: 1 only for the granted channel, never for a LOCKED channel. After a grant the pointer moves to granted+1 (mod N_CH).
- Handshake: word accepted when s_valid[c] & s_ready[c]. s_ready is independent of downstream; the BRAM is always writable.
- Address: region base = c << REG_AW; bram_addr = base + word count. Word count has REG_AW+1 bits; only the low REG_AW bits form the offset.
- Write latency: bram_we / bram_addr / bram_wdata registered, valid the cycle after acceptance. One write per cycle maximum.
- Limit: eff_limit = (cfg_limit==0 or > 2^REG_AW) ? 2^REG_AW : cfg_limit, sampled at the first word of each packet and held for the whole packet.
  - Word count < eff_limit: word written, count increments.
  - Otherwise: word accepted and dropped (bram_we=0), truncation flag set.
- Commit: pkt_done pulses the cycle after the write slot of the last word (two cycles after the s_last acceptance), with pkt_ch, pkt_len = stored count and pkt_trunc. These three hold their value until the next pkt_done. Counter and trunc flag clear on the IDLE re-entry.
- Simultaneous completions: only one word is granted per cycle, so two channels cannot complete in the same cycle; no pkt_done queue is needed.
- ch_release to a non-LOCKED channel: ignored. Release and new s_valid in the same cycle: the channel becomes eligible from the next cycle.
- ch_locked[c] = (state==LOCKED), registered.
- Reset mid-packet: the packet is discarded, no pkt_done, regions unlocked; BRAM contents are not cleared.

Decomposition:
- Shared package entries: channel-state enum (IDLE/RECV/LOCKED), default REG_AW/N_CH constants, NSK/VSK limit constants (512 / 1024) for the top-level cfg_limit defaults.
- One sub-module: rr_arbiter (N-request round-robin, one-hot grant, pointer update on grant).
- Per-channel FSM and counters live in a generate loop in the top module.

Test Plan:
- N_CH=2, cfg_limit=0: ch0 sends 4 words A0..A3 with last on A3 -> writes to addr 0..3 one cycle after each accept; pkt_done pulses with pkt_ch=0, pkt_len=4, pkt_trunc=0; ch_locked=01.
- Both channels continuously valid, 3-word packets -> grants alternate ch0/ch1; ch1 writes at 2048..2050; two pkt_done pulses in different cycles.
- cfg_limit=2, ch1 sends 5 words -> only addrs 2048, 2049 written; all 5 accepted; pkt_len=2, pkt_trunc=1.
- ch0 LOCKED, ch0 s_valid held high -> s_ready[0]=0 indefinitely; ch_release[0] pulse -> s_ready[0]=1 from the next cycle; new packet starts at addr 0.
- Reset asserted after 2 words of a ch0 packet -> all outputs 0 asynchronously, no pkt_done; after reset a fresh packet writes from addr 0.
- cfg_limit=2048 with a 2049-word packet -> last write at addr 2047, no wrap into ch1 region; pkt_len=2048, pkt_trunc=1.
